// File: rtl/serial_pkg.sv
// serial_pkg: receiver FSM state encoding and frame bit levels shared by both link ends
package serial_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} rx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input bit, reset to RST_VAL
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic areset_n,
  input  logic d,
  output logic q
);
  logic [1:0] ff_q, ff_d;
  always_comb ff_d = {ff_q[0], d};
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) ff_q <= {2{RST_VAL}};
    else ff_q <= ff_d;
  assign q = ff_q[1];
endmodule

// File: rtl/serial_rx_deser.sv
// serial_rx_deser: oversampled LSB-first start/stop receiver; define PARITY_RX_EN for an even-parity bit
module serial_rx_deser
  import serial_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OVS    = 16
) (
  input  logic              clk,
  input  logic              areset_n,
  input  logic              tick,
  input  logic              rxd,
  output logic [DATA_W-1:0] q,
  output logic              valid,
  output logic              frame_err,
  output logic              parity_err,
  output logic              busy
);
  localparam int TC_W = $clog2(OVS);
  localparam int BI_W = $clog2(DATA_W + 1);
  logic              rs, tc_end, tc_half;
  rx_state_t         state_q, state_d;
  logic [TC_W-1:0]   tc_q, tc_d;
  logic [BI_W-1:0]   bi_q, bi_d;
  logic [DATA_W-1:0] sr_q, sr_d, q_q, q_d;
  logic              valid_q, valid_d, frame_err_q, frame_err_d, busy_q, busy_d;
`ifdef PARITY_RX_EN
  logic              par_q, par_d, parity_err_q, parity_err_d;
`endif
  sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .areset_n(areset_n), .d(rxd), .q(rs));
  assign tc_end  = tick && tc_q == TC_W'(OVS - 1);
  assign tc_half = tick && tc_q == TC_W'(OVS / 2 - 1);
  always_comb begin
    state_d     = state_q;
    tc_d        = tc_end ? '0 : (tick ? tc_q + 1'b1 : tc_q);
    bi_d        = bi_q;
    sr_d        = sr_q;
    q_d         = q_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef PARITY_RX_EN
    par_d        = par_q;
    parity_err_d = 1'b0;
`endif
    case (state_q)
      IDLE:  if (rs == START_BIT) state_d = START;
      START: if (tc_half) state_d = rs == START_BIT ? DATA : IDLE;
      DATA: if (tc_end) begin
        sr_d = DATA_W'({rs, sr_q} >> 1);
        bi_d = bi_q + 1'b1;
`ifdef PARITY_RX_EN
        if (bi_q == BI_W'(DATA_W - 1)) state_d = PAR;
`else
        if (bi_q == BI_W'(DATA_W - 1)) state_d = STOP;
`endif
      end
`ifdef PARITY_RX_EN
      PAR: if (tc_end) begin
        par_d   = rs;
        state_d = STOP;
      end
`endif
      STOP: if (tc_end) begin
        if (rs == STOP_BIT) begin
          q_d     = sr_q;
          valid_d = 1'b1;
`ifdef PARITY_RX_EN
          parity_err_d = ^{sr_q, par_q};
`endif
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BRK;
        end
      end
      BRK:     if (rs == STOP_BIT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) begin
      tc_d = '0;
      bi_d = '0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or negedge areset_n)
    if (!areset_n) begin
      state_q     <= IDLE;
      tc_q        <= '0;
      bi_q        <= '0;
      sr_q        <= '0;
      q_q         <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef PARITY_RX_EN
      par_q        <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      tc_q        <= tc_d;
      bi_q        <= bi_d;
      sr_q        <= sr_d;
      q_q         <= q_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef PARITY_RX_EN
      par_q        <= par_d;
      parity_err_q <= parity_err_d;
`endif
    end
  assign q         = q_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef PARITY_RX_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_serial_rx_deser.sv
// tb_serial_rx_deser: directed frames at OVS=4 with a tick every second clock
module tb_serial_rx_deser;
  logic       clk = 1'b0, areset_n = 1'b1, tick = 1'b0, rxd = 1'b1;
  logic [7:0] q;
  logic       valid, frame_err, parity_err, busy;
  int         n_chk = 0, n_err = 0;
  int         n_valid = 0, n_ferr = 0, n_perr = 0;
  logic       busy_at_valid = 1'b1;
  logic [7:0] q_log [16];
  serial_rx_deser #(.DATA_W(8), .OVS(4)) dut (
    .clk(clk), .areset_n(areset_n), .tick(tick), .rxd(rxd), .q(q),
    .valid(valid), .frame_err(frame_err), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(negedge clk);
    tick = ~tick;
  end
  always @(negedge clk) begin
    if (valid) begin
      n_valid <= n_valid + 1;
      q_log[n_valid[3:0]] <= q;
      busy_at_valid <= busy;
    end
    if (frame_err) n_ferr <= n_ferr + 1;
    if (parity_err) n_perr <= n_perr + 1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask
  task automatic send_bit(input logic b);
    rxd = b;
    repeat (8) @(negedge clk);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic par_b, input logic stop_b);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef PARITY_RX_EN
    send_bit(par_b);
`else
    if (par_b) rxd = 1'b0;
`endif
    send_bit(stop_b);
  endtask
  initial begin
    #2 areset_n = 1'b0;
    idle(3);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_frame_err", 32'(frame_err), 32'h0);
    chk("rst_parity_err", 32'(parity_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    areset_n = 1'b1;
    idle(10);
    send_frame(8'hA5, 1'b0, 1'b1);
    idle(4);
    chk("a5_nvalid", 32'(n_valid), 32'd1);
    chk("a5_q", 32'(q), 32'hA5);
    chk("a5_nferr", 32'(n_ferr), 32'd0);
    chk("a5_busy_at_valid", 32'(busy_at_valid), 32'h0);
    chk("a5_busy_after", 32'(busy), 32'h0);
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(40);
    chk("3c_nferr", 32'(n_ferr), 32'd1);
    chk("3c_nvalid", 32'(n_valid), 32'd1);
    chk("3c_q_kept", 32'(q), 32'hA5);
    chk("brk_busy_low_line", 32'(busy), 32'h1);
    rxd = 1'b1;
    idle(8);
    chk("brk_busy_released", 32'(busy), 32'h0);
    chk("brk_no_new_frame", 32'(n_valid + n_ferr), 32'd2);
    rxd = 1'b0;
    idle(2);
    rxd = 1'b1;
    idle(2);
    chk("glitch_busy_start", 32'(busy), 32'h1);
    idle(12);
    chk("glitch_busy_idle", 32'(busy), 32'h0);
    chk("glitch_nvalid", 32'(n_valid), 32'd1);
    chk("glitch_nferr", 32'(n_ferr), 32'd1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    chk("middata_busy", 32'(busy), 32'h1);
    areset_n = 1'b0;
    idle(2);
    chk("middata_rst_busy", 32'(busy), 32'h0);
    chk("middata_rst_q", 32'(q), 32'h0);
    areset_n = 1'b1;
    idle(60);
    chk("middata_no_report", 32'(n_valid + n_ferr), 32'd2);
    send_frame(8'h0F, 1'b0, 1'b1);
    idle(4);
    chk("0f_q", 32'(q), 32'h0F);
    chk("0f_nvalid", 32'(n_valid), 32'd2);
    send_frame(8'h01, 1'b1, 1'b1);
    send_frame(8'hFE, 1'b1, 1'b1);
    idle(4);
    chk("b2b_nvalid", 32'(n_valid), 32'd4);
    chk("b2b_first_q", 32'(q_log[2]), 32'h01);
    chk("b2b_second_q", 32'(q_log[3]), 32'hFE);
    chk("b2b_nferr", 32'(n_ferr), 32'd1);
`ifdef PARITY_RX_EN
    send_frame(8'h07, 1'b1, 1'b1);
    idle(4);
    chk("par_ok_nvalid", 32'(n_valid), 32'd5);
    chk("par_ok_nperr", 32'(n_perr), 32'd0);
    send_frame(8'h07, 1'b0, 1'b1);
    idle(4);
    chk("par_bad_nvalid", 32'(n_valid), 32'd6);
    chk("par_bad_nperr", 32'(n_perr), 32'd1);
    chk("par_bad_q", 32'(q), 32'h07);
`else
    chk("noparity_nperr", 32'(n_perr), 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
